enc8to3_q: RTL and testbench

- Sequential 8-to-3 encoder: the inverse of the team's 3-to-8 one-hot decoder.
- Collects single-cycle event strobes on 8 lines into a pending register.
- Presents one pending event at a time as a 3-bit code with a valid/ready handshake.
- Bit i of din always maps to code i, so decoding the code with the 3-to-8 decoder reproduces the served bit.

---
 rtl/enc8to3_q_if.sv | 28 ++
 rtl/enc8to3_q.sv | 109 ++++++++++
 tb/tb_enc8to3_q.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/enc8to3_q_if.sv
// Event/code handshake bundle for the sequential 8-to-3 encoder.
// The slave side is the encoder; the master side is the event source and code consumer.
interface enc8to3_q_if;
    logic [7:0] din;
    logic       ready;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pend;
    logic       ovf;

    modport master (
        output din,
        output ready,
        input  code,
        input  valid,
        input  pend,
        input  ovf
    );

    modport slave (
        input  din,
        input  ready,
        output code,
        output valid,
        output pend,
        output ovf
    );
endinterface

// File: rtl/enc8to3_q.sv
// Sequential 8-to-3 encoder: collects event strobes and serves them one code at a time.
// Define ENC_RR_EN for round-robin selection instead of fixed highest-index priority.
//
// state | meaning
// IDLE  | no code presented, valid=0
// SHOW  | code holds a pending event, valid=1
module enc8to3_q (
    input  logic        clk,
    input  logic        rst_n,
    enc8to3_q_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    logic [0:0] state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [7:0] pend_q, pend_d;
    logic       ovf_q, ovf_d;

    logic       valid;
    logic       take;
    logic [7:0] clr;
    logic [7:0] m;
    logic [2:0] sel;

    assign valid = (state_q == SHOW);
    assign take  = valid & bus.ready;
    assign clr   = take ? (8'b0000_0001 << code_q) : 8'h00;
    // Masking the served bit keeps a grant from repeating on the next cycle.
    assign m     = pend_q & ~clr;

    assign pend_d = m | bus.din;
    assign ovf_d  = ovf_q | (|(bus.din & m));

`ifdef ENC_RR_EN
    logic [2:0] last_q, last_d;

    assign last_d = take ? code_q : last_q;

    // Walk downward so the closest bit above last is the final assignment.
    always_comb begin
        sel = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            if (m[last_q + 3'(k)]) begin
                sel = last_q + 3'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 3'b111;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                sel = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (|m) begin
                    code_d  = sel;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (bus.ready) begin
                    if (|m) begin
                        code_d = sel;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= 3'b000;
            pend_q  <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.code  = code_q;
    assign bus.valid = valid;
    assign bus.pend  = pend_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_enc8to3_q.sv
// Directed self-checking bench for enc8to3_q (fixed priority or ENC_RR_EN round-robin).
module tb_enc8to3_q;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    enc8to3_q_if bus ();

    enc8to3_q dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.din   = 8'h00;
        bus.ready = 1'b0;
        #1 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        bus.din   = 8'hFF;
        bus.ready = 1'b1;
        #2;
        chk("rst_pend",  bus.pend, 8'h00);
        chk("rst_code",  {5'd0, bus.code}, 8'h00);
        chk("rst_valid", {7'd0, bus.valid}, 8'h00);
        chk("rst_ovf",   {7'd0, bus.ovf}, 8'h00);
        step();
        chk("rst_ignores_din", bus.pend, 8'h00);
        do_reset();

        // single strobe on line 2
        bus.din = 8'h04; bus.ready = 1'b1;
        step();
        bus.din = 8'h00;
        chk("single_pend_e1",  bus.pend, 8'h04);
        chk("single_valid_e1", {7'd0, bus.valid}, 8'h00);
        step();
        chk("single_code_e2",  {5'd0, bus.code}, 8'h02);
        chk("single_valid_e2", {7'd0, bus.valid}, 8'h01);
        step();
        chk("single_valid_e3", {7'd0, bus.valid}, 8'h00);
        chk("single_pend_e3",  bus.pend, 8'h00);
        chk("single_ovf",      {7'd0, bus.ovf}, 8'h00);

        // all lines at once, ready held high
        do_reset();
        bus.din = 8'hFF; bus.ready = 1'b1;
        step();
        bus.din = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step();
`ifdef ENC_RR_EN
            chk("ff_code", {5'd0, bus.code}, 8'(i));
`else
            chk("ff_code", {5'd0, bus.code}, 8'(7 - i));
`endif
            chk("ff_valid", {7'd0, bus.valid}, 8'h01);
        end
        step();
        chk("ff_done_valid", {7'd0, bus.valid}, 8'h00);
        chk("ff_done_pend",  bus.pend, 8'h00);

        // hold under ready=0, then drain two events
        do_reset();
        bus.din = 8'h81; bus.ready = 1'b0;
        step();
        bus.din = 8'h00;
        for (int c = 0; c < 5; c++) begin
            step();
`ifdef ENC_RR_EN
            chk("hold_code", {5'd0, bus.code}, 8'h00);
`else
            chk("hold_code", {5'd0, bus.code}, 8'h07);
`endif
            chk("hold_valid", {7'd0, bus.valid}, 8'h01);
        end
        bus.ready = 1'b1;
        step();
`ifdef ENC_RR_EN
        chk("hold_second_code", {5'd0, bus.code}, 8'h07);
`else
        chk("hold_second_code", {5'd0, bus.code}, 8'h00);
`endif
        chk("hold_second_valid", {7'd0, bus.valid}, 8'h01);
        chk("hold_second_pend",  bus.pend, 8'h01 << bus.code);
        step();
        chk("hold_idle_valid", {7'd0, bus.valid}, 8'h00);
        chk("hold_idle_pend",  bus.pend, 8'h00);

        // duplicate strobe on a pending line sets sticky ovf
        do_reset();
        bus.din = 8'h10; bus.ready = 1'b0;
        step();
        bus.din = 8'h00;
        step();
        chk("ovf_code",  {5'd0, bus.code}, 8'h04);
        chk("ovf_valid", {7'd0, bus.valid}, 8'h01);
        chk("ovf_pre",   {7'd0, bus.ovf}, 8'h00);
        bus.din = 8'h10;
        step();
        bus.din = 8'h00;
        chk("ovf_set",   {7'd0, bus.ovf}, 8'h01);
        chk("ovf_merge", bus.pend, 8'h10);
        bus.ready = 1'b1;
        step();
        chk("ovf_one_grant_valid", {7'd0, bus.valid}, 8'h00);
        chk("ovf_one_grant_pend",  bus.pend, 8'h00);
        step();
        chk("ovf_still_idle", {7'd0, bus.valid}, 8'h00);
        chk("ovf_sticky",     {7'd0, bus.ovf}, 8'h01);

        // strobe on the served line in the take cycle re-arms it
        do_reset();
        bus.din = 8'h08; bus.ready = 1'b0;
        step();
        bus.din = 8'h00;
        step();
        chk("rearm_code",  {5'd0, bus.code}, 8'h03);
        chk("rearm_valid", {7'd0, bus.valid}, 8'h01);
        bus.ready = 1'b1; bus.din = 8'h08;
        step();
        bus.din = 8'h00;
        chk("rearm_gap_valid", {7'd0, bus.valid}, 8'h00);
        chk("rearm_gap_pend",  bus.pend, 8'h08);
        chk("rearm_no_ovf",    {7'd0, bus.ovf}, 8'h00);
        step();
        chk("rearm_again_code",  {5'd0, bus.code}, 8'h03);
        chk("rearm_again_valid", {7'd0, bus.valid}, 8'h01);
        step();
        chk("rearm_done_valid", {7'd0, bus.valid}, 8'h00);
        chk("rearm_done_pend",  bus.pend, 8'h00);

        // asynchronous reset mid-handshake
        do_reset();
        bus.din = 8'h3C; bus.ready = 1'b0;
        step();
        bus.din = 8'h00;
        step();
        chk("arst_pre_valid", {7'd0, bus.valid}, 8'h01);
        chk("arst_pre_pend",  bus.pend, 8'h3C);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", {7'd0, bus.valid}, 8'h00);
        chk("arst_pend",  bus.pend, 8'h00);
        chk("arst_code",  {5'd0, bus.code}, 8'h00);
        #2 rst_n = 1'b1;
        bus.ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("arst_after_valid", {7'd0, bus.valid}, 8'h00);
            chk("arst_after_pend",  bus.pend, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
